spi_responder: RTL and testbench

SPI target that terminates the 4-wire serial link driven by the team's `spi_master` (8-bit address, 24-bit data, mode-3 style: master shifts on SCLK falling edge, samples on rising edge). It oversamples SCLK/CS/DIN in the fabric clock domain, decodes address/data frames, issues register write and read strobes to a fabric register file, and drives DOUT with read data or an AD7794-style RDY status. It is used to emulate a peripheral for loopback test and to expose FPGA registers over the same bus the ADC uses.

---
 rtl/spi_responder.sv | 217 +++++++++++++++++++++
 tb/tb_spi_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// SPI target for the spi_master link: oversamples SCLK/CS/DIN in the fabric clock domain,
// decodes address/data frames into register write/read strobes and drives DOUT/RDY.
module spi_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  din,
  output logic                  dout,
  output logic                  dout_oe,
  input  logic                  data_ready,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-2:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_strobe,
  output logic [ADDR_WIDTH-2:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frame_err
);

  localparam int unsigned MaxW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntW = $clog2(MaxW + 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0] DataAll  = CntW'(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StAddr, StWdata, StRdata} state_e;

  state_e state_q, state_d;

  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;
  logic din_s1, din_s2;
  logic armed_q;

  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d;
  logic [DATA_WIDTH-1:0] dout_sr_q, dout_sr_d;
  logic                  dout_q, dout_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic                  rd_strobe_q, rd_strobe_d;
  logic                  frame_err_q, frame_err_d;
  logic [ADDR_WIDTH-2:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-2:0] rd_addr_q, rd_addr_d;
  logic [1:0]            cap_q, cap_d;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] data_next;

  // CS sync flops reset low so a CS already low at reset release never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_d  <= 1'b1;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
      din_s1  <= 1'b0;
      din_s2  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      din_s1  <= din;
      din_s2  <= din_s1;
      if (cs_s2) armed_q <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign cs_fall   = ~cs_s2 & cs_d;
  assign addr_next = {addr_sr_q[ADDR_WIDTH-2:0], din_s2};
  assign data_next = {data_sr_q[DATA_WIDTH-2:0], din_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cs_fall) state_d = StAddr;
      StAddr: begin
        if (cs_rise) state_d = StIdle;
        else if (sclk_rise && bit_cnt_q == AddrLast)
          state_d = addr_next[ADDR_WIDTH-1] ? StRdata : StWdata;
      end
      StWdata: begin
        if (cs_rise) state_d = StIdle;
        else if (sclk_rise && bit_cnt_q == DataLast) state_d = StAddr;
      end
      StRdata: begin
        if (cs_rise) state_d = StIdle;
        else if (sclk_rise && bit_cnt_q == DataAll) state_d = StAddr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    dout_sr_d   = dout_sr_q;
    dout_d      = ~data_ready;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    cap_d       = {cap_q[0], rd_strobe_q};
    unique case (state_q)
      StIdle: if (cs_fall) bit_cnt_d = '0;
      StAddr: begin
        if (cs_rise) begin
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          addr_sr_d = addr_next;
          if (bit_cnt_q == AddrLast) begin
            bit_cnt_d = '0;
            if (addr_next[ADDR_WIDTH-1]) begin
              rd_strobe_d = 1'b1;
              rd_addr_d   = addr_next[ADDR_WIDTH-2:0];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StWdata: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          data_sr_d = data_next;
          if (bit_cnt_q == DataLast) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_sr_q[ADDR_WIDTH-2:0];
            wr_data_d   = data_next;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StRdata: begin
        dout_d = dout_q;
        if (cs_rise) begin
          frame_err_d = 1'b1;
        end else if (sclk_fall && bit_cnt_q != DataAll) begin
          dout_d    = dout_sr_q[DATA_WIDTH-1];
          dout_sr_d = {dout_sr_q[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end else if (sclk_rise && bit_cnt_q == DataAll) begin
          bit_cnt_d = '0;
        end
      end
      default: ;
    endcase
    // Fabric read data is valid two cycles after rd_strobe.
    if (cap_q[1]) dout_sr_d = rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      dout_sr_q   <= '0;
      dout_q      <= 1'b1;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      cap_q       <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      dout_sr_q   <= dout_sr_d;
      dout_q      <= dout_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      cap_q       <= cap_d;
    end
  end

  assign dout      = dout_q;
  assign dout_oe   = armed_q & ~cs_s2;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign frame_err = frame_err_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: acts as a mode-3 SPI master and a fixed-data fabric.
module tb_spi_responder;

  localparam int Half = 6;

  logic        clk = 1'b0;
  logic        rst, sclk, cs, din, data_ready;
  logic        dout, dout_oe, wr_strobe, rd_strobe, frame_err;
  logic [6:0]  wr_addr, rd_addr;
  logic [23:0] wr_data, rd_data;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  logic [6:0]  log_addr [8];
  logic [23:0] log_data [8];
  logic [6:0]  rd_seen_addr;
  logic [31:0] miso;

  spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs         (cs),
    .din        (din),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .data_ready (data_ready),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_strobe  (rd_strobe),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Each high cycle of a strobe is counted, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (wr_cnt < 8) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (rd_strobe) begin
      rd_seen_addr = rd_addr;
      rd_cnt++;
    end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] word, input int nbits, output logic [31:0] m);
    m = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      din  = word[31-i];
      repeat (Half) @(negedge clk);
      m    = {m[30:0], dout};
      sclk = 1'b1;
      repeat (Half) @(negedge clk);
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_dout"}, dout, 1);
    check({pfx, "_dout_oe"}, dout_oe, 0);
    check({pfx, "_wr_strobe"}, wr_strobe, 0);
    check({pfx, "_rd_strobe"}, rd_strobe, 0);
    check({pfx, "_frame_err"}, frame_err, 0);
    check({pfx, "_wr_addr"}, wr_addr, 0);
    check({pfx, "_wr_data"}, wr_data, 0);
    check({pfx, "_rd_addr"}, rd_addr, 0);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b1; cs = 1'b1; din = 1'b0;
    data_ready = 1'b0; rd_data = 24'h123456;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Write 0x05 <- 0xA5C3F0
    cs_low();
    shift_bits({8'h05, 24'hA5C3F0}, 32, miso);
    cs_high();
    check("wr1_count", wr_cnt, 1);
    check("wr1_addr", log_addr[0], 7'h05);
    check("wr1_data", log_data[0], 24'hA5C3F0);
    check("wr1_port_data", wr_data, 24'hA5C3F0);
    check("wr1_no_err", err_cnt, 0);

    // Read 0x83, fabric supplies 0x123456
    cs_low();
    shift_bits({8'h83, 24'h000000}, 32, miso);
    cs_high();
    check("rd_count", rd_cnt, 1);
    check("rd_addr", rd_seen_addr, 7'h03);
    check("rd_port_addr", rd_addr, 7'h03);
    check("rd_dout_data", miso[23:0], 24'h123456);
    check("rd_no_wr", wr_cnt, 1);
    check("rd_no_err", err_cnt, 0);

    // Abort after 12 bits of a write to 0x05
    cs_low();
    shift_bits({8'h05, 24'h3C0000}, 12, miso);
    cs_high();
    check("abort_err", err_cnt, 1);
    check("abort_no_wr", wr_cnt, 1);
    check("abort_wr_addr", wr_addr, 7'h05);
    check("abort_wr_data", wr_data, 24'hA5C3F0);

    // Two writes under one CS
    cs_low();
    shift_bits({8'h01, 24'h000001}, 32, miso);
    shift_bits({8'h02, 24'hFFFFFF}, 32, miso);
    cs_high();
    check("b2b_count", wr_cnt, 3);
    check("b2b_addr0", log_addr[1], 7'h01);
    check("b2b_data0", log_data[1], 24'h000001);
    check("b2b_addr1", log_addr[2], 7'h02);
    check("b2b_data1", log_data[2], 24'hFFFFFF);
    check("b2b_no_err", err_cnt, 1);

    // RDY status on an idle selected bus
    cs_low();
    data_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("stat_ready_dout", dout, 0);
    check("stat_oe_on", dout_oe, 1);
    data_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("stat_busy_dout", dout, 1);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    check("stat_oe_off", dout_oe, 0);
    check("stat_no_err", err_cnt, 1);

    // Reset in the middle of a write
    cs_low();
    shift_bits({8'h05, 24'h777777}, 20, miso);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_wr", wr_cnt, 3);
    check("midrst_no_err", err_cnt, 1);

    cs_low();
    shift_bits({8'h07, 24'h00ABCD}, 32, miso);
    cs_high();
    check("post_rst_count", wr_cnt, 4);
    check("post_rst_addr", log_addr[3], 7'h07);
    check("post_rst_data", log_data[3], 24'h00ABCD);
    check("post_rst_no_err", err_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
